uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_tx instance among NUM_REQ byte-stream requesters (result pixels, status, debug).
//  Grants are round-robin and held for a whole packet; an optional ID header byte is sent before each packet.
//  Paces bytes by the uart_tx valid/ready handshake: ready drops the cycle after acceptance and returns when the stop bit ends.
// PARAMETERS
//  NUM_REQ      4      number of requesters, 2..16
//  HDR_EN       1      1: send header byte HDR_BASE|grant_id before each packet; 0: no header
//  HDR_BASE     8'hA0  header base value; low 4 bits are overwritten with the requester ID
//  MAX_PKT_LEN  256    payload bytes per grant before forced release, >=1
// PORTS
//  clk          in   1            system clock
//  rst_n        in   1            asynchronous reset, active-low
//  req_valid    in   NUM_REQ      requester i has a byte on req_data[i*8+:8]
//  req_data     in   8*NUM_REQ    packed requester bytes
//  req_last     in   NUM_REQ      current byte of requester i ends its packet
//  req_ready    out  NUM_REQ      byte of requester i is consumed this cycle (valid&ready)
//  tx_data      out  8            to uart_tx.data_in
//  tx_valid     out  1            to uart_tx.valid
//  tx_ready     in   1            from uart_tx.ready
//  busy         out  1            grant held (state != IDLE)
//  grant_id     out  $clog2(NUM_REQ)  current/last granted requester
//  pkt_done     out  1            1-cycle pulse: packet ended by req_last
//  pkt_trunc    out  1            1-cycle pulse: grant released at MAX_PKT_LEN without req_last
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, rr_ptr=NUM_REQ-1, grant_id=0, byte_cnt=0, pkt_done=pkt_trunc=0.
//   Combinational outputs follow IDLE: tx_valid=0, tx_data=0, req_ready=0, busy=0. Reset mid-byte aborts the packet.
//  States: IDLE, HDR, DATA, WAIT_LO, WAIT_HI.
//  IDLE: if |req_valid: grant_id <= first i with req_valid[i], searching from rr_ptr+1 with wrap; rr_ptr <= that i;
//   byte_cnt <= 0; next = HDR if HDR_EN, else DATA. Arbitration takes 1 cycle.
//  HDR: tx_valid=1, tx_data = {HDR_BASE[7:4], grant_id zero-extended to 4 bits}. When tx_ready=1, go to WAIT_LO (hdr_sent flag set).
//  DATA: tx_valid = req_valid[g]; tx_data = req_data[g]; req_ready[g] = tx_ready (others 0).
//   Transfer = req_valid[g] & tx_ready. On transfer: byte_cnt++, latch last_flag = req_last[g], go to WAIT_LO.
//   No transfer: hold in DATA. The grant is never released while waiting for the owner.
//  WAIT_LO: tx_valid=0; wait for tx_ready=0 (uart_tx took the byte), then go to WAIT_HI.
//  WAIT_HI: wait for tx_ready=1 (stop bit complete), then choose the next state:
//   After the header: go to DATA.
//   last_flag=1: pulse pkt_done, go to IDLE.
//   byte_cnt==MAX_PKT_LEN and last_flag=0: pulse pkt_trunc, go to IDLE. The requester resumes in a later grant without a new-header guarantee.
//   Otherwise: go to DATA.
//  Spacing: each byte costs 1 transfer cycle + uart frame time. Min IDLE->first tx_valid is 1 cycle.
//  Only one tx_valid/tx_ready overlap per byte. tx_valid is never high in WAIT_LO, WAIT_HI or IDLE.
//  rr_ptr updates only at grant. Requests arriving during a packet are served after it in round-robin order.
//  Simultaneous req_valid on all inputs, each serves one packet in turn: ptr+1, ptr+2, ...
//  byte_cnt width is $clog2(MAX_PKT_LEN+1); it saturates at MAX_PKT_LEN and never wraps.
//  req_last on a byte counted as MAX_PKT_LEN gives pkt_done only, not pkt_trunc.
//  req_data/req_last are sampled only in the transfer cycle. Changes while req_ready=0 are legal.
// TESTING
//  Drive a behavioural uart_tx model (ready=0 for 20 cycles after accept) and check every case against a scoreboard.
//  1 Reset: rst_n=0 mid-DATA -> tx_valid=0, busy=0, req_ready=0 immediately; after release, first grant goes to req 0.
//  2 Single packet: req1 sends 0x11,0x22,0x33(last), HDR_EN=1 -> tx bytes A1,11,22,33.
//    Exactly 4 tx handshakes, 1 pkt_done, then busy=0.
//  3 Round-robin: req0,req2,req3 all hold 1-byte packets -> headers A0,A2,A3 in that order.
//    Refiring req0 alone afterwards -> A0 again.
//  4 Packet hold: req1 requests during req0's 3-byte packet -> no req1 byte before req0's last byte; req1's header follows it.
//  5 Truncation: MAX_PKT_LEN=4, req2 streams 6 bytes without last -> 4 bytes sent, pkt_trunc pulses once.
//    A new A2 header precedes the remaining 2 bytes.
//  6 Stall/HDR_EN=0: req3 drops req_valid for 50 cycles mid-packet -> grant and tx_valid wait; no header bytes ever appear.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester byte streams and the uart_tx handshake that the
// arbiter sits between.
//   req_valid/req_data/req_last  requester side: byte offered, packed 8 bits per requester
//   req_ready                    requester side: byte consumed this cycle
//   tx_data/tx_valid             toward uart_tx data_in/valid
//   tx_ready                     from uart_tx ready
// Modports:
//   master  the environment: requesters plus the uart_tx instance
//   slave   the arbiter itself
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart_tx among NUM_REQ byte-stream requesters. A round-robin
// grant is taken in IDLE and held for a whole packet (or until MAX_PKT_LEN
// bytes have gone out). With HDR_EN=1 each grant starts with the header
// byte {HDR_BASE[7:4], grant_id}. Bytes are paced purely by the uart_tx
// handshake: after an accept, ready falls and rises again at end of stop bit.
// Ports:
//   clk        system clock
//   rst_n      asynchronous reset, active-low
//   bus        uart_tx_arbiter_if.slave (requester streams + uart_tx handshake)
//   busy       a grant is held (state != IDLE)
//   grant_id   current / last granted requester
//   pkt_done   1-cycle pulse: packet closed by req_last
//   pkt_trunc  1-cycle pulse: grant released at MAX_PKT_LEN without req_last
// The bus instance must be built with the same NUM_REQ as this module.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int           NUM_REQ     = 4,
  parameter int           HDR_EN      = 1,
  parameter logic [7:0]   HDR_BASE    = 8'hA0,
  parameter int           MAX_PKT_LEN = 256,
  localparam int          GID_W       = $clog2(NUM_REQ),
  localparam int          CNT_W       = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_tx_arbiter_if.slave    bus,
  output logic                busy,
  output logic [GID_W-1:0]    grant_id,
  output logic                pkt_done,
  output logic                pkt_trunc
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PKT_LEN);
  localparam logic [GID_W-1:0] PTR_RST = GID_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WAIT_LO,
    WAIT_HI
  } state_t;

  state_t            state_reg, state_next;
  logic [GID_W-1:0]  grant_id_reg, grant_id_next;
  logic [GID_W-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]  byte_cnt_reg, byte_cnt_next;
  logic              last_flag_reg, last_flag_next;
  logic              hdr_sent_reg, hdr_sent_next;
  logic              pkt_done_reg, pkt_done_next;
  logic              pkt_trunc_reg, pkt_trunc_next;

  // -------------------------------------------------------------------------
  // Per-requester byte view of the packed data bus
  // -------------------------------------------------------------------------
  logic [7:0] req_byte [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_byte[gi] = bus.req_data[gi*8 +: 8];
  end

  // -------------------------------------------------------------------------
  // Round-robin pick: first valid requester after rr_ptr, wrapping around.
  // The pointer itself is offset 0 of the search only on the last step, so
  // the previous owner has the lowest priority next time.
  // -------------------------------------------------------------------------
  logic [GID_W-1:0] arb_idx;
  logic [GID_W-1:0] arb_pick;
  logic             arb_found;

  always_comb begin
    arb_idx   = '0;
    arb_pick  = '0;
    arb_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      arb_idx = GID_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
      if (!arb_found && bus.req_valid[arb_idx]) begin
        arb_found = 1'b1;
        arb_pick  = arb_idx;
      end
    end
  end

  // Header low nibble carries the requester ID, zero-extended
  logic [3:0] hdr_id;
  assign hdr_id = 4'(grant_id_reg);

  // Owner's handshake in DATA; the grant never moves while this is low
  logic owner_valid;
  assign owner_valid = bus.req_valid[grant_id_reg];

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      grant_id_reg  <= '0;
      rr_ptr_reg    <= PTR_RST;
      byte_cnt_reg  <= '0;
      last_flag_reg <= 1'b0;
      hdr_sent_reg  <= 1'b0;
      pkt_done_reg  <= 1'b0;
      pkt_trunc_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      grant_id_reg  <= grant_id_next;
      rr_ptr_reg    <= rr_ptr_next;
      byte_cnt_reg  <= byte_cnt_next;
      last_flag_reg <= last_flag_next;
      hdr_sent_reg  <= hdr_sent_next;
      pkt_done_reg  <= pkt_done_next;
      pkt_trunc_reg <= pkt_trunc_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and handshake outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    grant_id_next  = grant_id_reg;
    rr_ptr_next    = rr_ptr_reg;
    byte_cnt_next  = byte_cnt_reg;
    last_flag_next = last_flag_reg;
    hdr_sent_next  = hdr_sent_reg;
    pkt_done_next  = 1'b0;
    pkt_trunc_next = 1'b0;
    bus.tx_valid   = 1'b0;
    bus.tx_data    = 8'h00;
    bus.req_ready  = '0;

    case (state_reg)
      IDLE: begin
        if (arb_found) begin
          grant_id_next  = arb_pick;
          rr_ptr_next    = arb_pick;
          byte_cnt_next  = '0;
          last_flag_next = 1'b0;
          hdr_sent_next  = 1'b0;
          state_next     = (HDR_EN != 0) ? HDR : DATA;
        end
      end

      HDR: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = {HDR_BASE[7:4], hdr_id};
        if (bus.tx_ready) begin
          hdr_sent_next = 1'b1;
          state_next    = WAIT_LO;
        end
      end

      DATA: begin
        bus.tx_valid                = owner_valid;
        bus.tx_data                 = req_byte[grant_id_reg];
        bus.req_ready[grant_id_reg] = bus.tx_ready;
        if (owner_valid && bus.tx_ready) begin
          // Saturate so a long stream can never wrap back below MAX_CNT
          if (byte_cnt_reg != MAX_CNT) begin
            byte_cnt_next = byte_cnt_reg + CNT_W'(1);
          end
          last_flag_next = bus.req_last[grant_id_reg];
          state_next     = WAIT_LO;
        end
      end

      // uart_tx drops ready the cycle after it takes a byte
      WAIT_LO: begin
        if (!bus.tx_ready) begin
          state_next = WAIT_HI;
        end
      end

      // ready returns once the stop bit has gone out
      WAIT_HI: begin
        if (bus.tx_ready) begin
          if (hdr_sent_reg) begin
            hdr_sent_next = 1'b0;
            state_next    = DATA;
          end else if (last_flag_reg) begin
            // req_last wins even when the byte count is exactly at the limit
            pkt_done_next = 1'b1;
            state_next    = IDLE;
          end else if (byte_cnt_reg == MAX_CNT) begin
            pkt_trunc_next = 1'b1;
            state_next     = IDLE;
          end else begin
            state_next = DATA;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy      = (state_reg != IDLE);
  assign grant_id  = grant_id_reg;
  assign pkt_done  = pkt_done_reg;
  assign pkt_trunc = pkt_trunc_reg;

endmodule
